// File: rtl/viterbi_pkg.sv
// Shared code constants for the convolutional encoder and Viterbi decoder:
// constraint length, generators, frame limits, symbol bit order, helpers.
package viterbi_pkg;

    localparam int K         = 5;
    localparam int M         = K - 1;
    localparam int MAX_FRAME = 32;
    localparam int LEN_BITS  = 6;

    localparam logic [K-1:0] G0_OCT = 5'o23;
    localparam logic [K-1:0] G1_OCT = 5'o35;

    // G0 output lands on the even bit of each 2-bit symbol
    localparam int SYM_G0_BIT = 0;
    localparam int SYM_G1_BIT = 1;

    localparam int T_W  = $clog2(MAX_FRAME) + 1;
    localparam int NB   = MAX_FRAME / 8;
    localparam int NB_W = $clog2(NB) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ENCODE,
        ST_SEND,
        ST_START
    } enc_state_t;

    typedef struct packed {
        logic [T_W-1:0]  l_msg;
        logic [T_W-1:0]  l_sym;
        logic [NB_W-1:0] nbytes;
    } frame_cfg_t;

    // ceil((l + M) / 4) * 4
    function automatic logic [T_W-1:0] sym_len(input logic [T_W-1:0] l);
        logic [T_W+1:0] s;
        s = {2'b00, l} + (T_W+2)'(M + 3);
        s[1:0] = 2'b00;
        return T_W'(s);
    endfunction

    // ceil(l / 8)
    function automatic logic [NB_W-1:0] byte_cnt(input logic [T_W-1:0] l);
        logic [T_W+1:0] s;
        s = {2'b00, l} + (T_W+2)'(7);
        return NB_W'(s >> 3);
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Combinational rate-1/2 encoder step: from the new bit b and the shift
// register sr, produce {g1,g0} and the next shift register value.
// Ports: b, sr (in); sym, sr_next (out).
module conv_enc_core
    import viterbi_pkg::*;
#(
    parameter int           CK  = K,
    parameter logic [CK-1:0] CG0 = G0_OCT,
    parameter logic [CK-1:0] CG1 = G1_OCT
) (
    input  logic          b,
    input  logic [CK-2:0] sr,
    output logic [1:0]    sym,
    output logic [CK-2:0] sr_next
);

    logic [CK-1:0] r;

    // Newest bit sits at the MSB, matching the octal tap convention
    assign r                = {b, sr};
    assign sym[SYM_G0_BIT]  = ^(r & CG0);
    assign sym[SYM_G1_BIT]  = ^(r & CG1);
    assign sr_next          = r[CK-1:1];

endmodule

// File: rtl/conv_frame_encoder.sv
// Frame encoder: loads a packed message, convolutionally encodes it with a
// zero-flushed tail, packs 4 symbols per byte and hands them to the decoder.
// Ports: clk, rst, go, msg_len, msg_byte, msg_valid (in); msg_ready (out);
//        sym_byte, sym_valid (out); sym_ready (in); start_out, busy, len_err (out).
module conv_frame_encoder
    import viterbi_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  logic [LEN_BITS-1:0] msg_len,
    input  logic [7:0]          msg_byte,
    input  logic                msg_valid,
    output logic                msg_ready,
    output logic [7:0]          sym_byte,
    output logic                sym_valid,
    input  logic                sym_ready,
    output logic                start_out,
    output logic                busy,
    output logic                len_err
);

    localparam int SB_W = $clog2(MAX_FRAME);

    enc_state_t          state;
    enc_state_t          state_nx;
    frame_cfg_t          cfg;
    logic [NB_W-1:0]     n;
    logic [MAX_FRAME-1:0] msg_buf;
    logic [M-1:0]        sr;
    logic [T_W-1:0]      t;
    logic [7:0]          sym_q;
    logic                len_err_q;

    logic                len_ok;
    logic                cur_bit;
    logic [1:0]          sym;
    logic [M-1:0]        sr_next;
    logic [7:0]          byte_mask;
    logic [SB_W-1:0]     slot_base;
    logic                load_last;

    assign len_ok = (msg_len != '0) &&
                    (msg_len <= LEN_BITS'(MAX_FRAME - M));

    assign slot_base = {n[NB_W-2:0], 3'b000};
    assign load_last = msg_valid && (n == cfg.nbytes - NB_W'(1));

    // Bits past the message length are stored as zero
    always_comb begin
        byte_mask = '0;
        for (int i = 0; i < 8; i++) begin
            byte_mask[i] =
                (T_W'(slot_base) + T_W'(i)) < cfg.l_msg;
        end
    end

    assign cur_bit = (t < cfg.l_msg) ? msg_buf[t[T_W-2:0]] : 1'b0;

    conv_enc_core u_core (
        .b       (cur_bit),
        .sr      (sr),
        .sym     (sym),
        .sr_next (sr_next)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (go && len_ok) state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                if (load_last) state_nx = ST_ENCODE;
            end
            ST_ENCODE: begin
                if (t[1:0] == 2'd3) state_nx = ST_SEND;
            end
            ST_SEND: begin
                if (sym_ready) begin
                    state_nx = (t == cfg.l_sym) ? ST_START
                                                : ST_ENCODE;
                end
            end
            ST_START: begin
                if (sym_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cfg       <= '0;
            n         <= '0;
            msg_buf   <= '0;
            sr        <= '0;
            t         <= '0;
            sym_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            state     <= state_nx;
            len_err_q <= (state == ST_IDLE) && go && !len_ok;
            unique case (state)
                ST_IDLE: begin
                    if (go && len_ok) begin
                        cfg.l_msg  <= T_W'(msg_len);
                        cfg.l_sym  <= sym_len(T_W'(msg_len));
                        cfg.nbytes <= byte_cnt(T_W'(msg_len));
                        n          <= '0;
                        t          <= '0;
                        sr         <= '0;
                        msg_buf    <= '0;
                    end
                end
                ST_LOAD: begin
                    if (msg_valid) begin
                        msg_buf[slot_base +: 8] <= msg_byte & byte_mask;
                        n <= n + NB_W'(1);
                    end
                end
                ST_ENCODE: begin
                    sym_q[{t[1:0], 1'b0} +: 2] <= sym;
                    sr <= sr_next;
                    t  <= t + T_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign msg_ready = (state == ST_LOAD);
    assign sym_valid = (state == ST_SEND);
    assign sym_byte  = sym_q;
    assign start_out = (state == ST_START) && sym_ready;
    assign busy      = (state != ST_IDLE);
    assign len_err   = len_err_q;

endmodule

// File: tb/tb_conv_frame_encoder.sv
// Randomized bench for conv_frame_encoder with a bit-level convolution
// model, plus directed frames pinned to hand-computed symbol bytes.
module tb_conv_frame_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       go;
    logic [5:0] msg_len;
    logic [7:0] msg_byte;
    logic       msg_valid;
    logic       msg_ready;
    logic [7:0] sym_byte;
    logic       sym_valid;
    logic       sym_ready;
    logic       start_out;
    logic       busy;
    logic       len_err;

    conv_frame_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .msg_len   (msg_len),
        .msg_byte  (msg_byte),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .sym_byte  (sym_byte),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .start_out (start_out),
        .busy      (busy),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int starts      = 0;
    int last_xfer   = 0;
    int last_start  = 0;
    int ready_pct   = 100;
    bit hold_low    = 1'b0;
    bit expect_start = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] cur_bytes[4];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference: direct convolution of the zero-padded bit sequence with
    // the octal generators; MSB of a generator multiplies the newest bit.
    function automatic void model(input int len);
        bit [4:0] g0 = 5'o23;
        bit [4:0] g1 = 5'o35;
        bit       u[32];
        bit [7:0] b;
        int       lsym;
        bit       y0, y1;
        lsym = ((len + 4 + 3) / 4) * 4;
        for (int i = 0; i < 32; i++)
            u[i] = (i < len) ? cur_bytes[i / 8][i % 8] : 1'b0;
        b = '0;
        for (int i = 0; i < lsym; i++) begin
            y0 = 1'b0;
            y1 = 1'b0;
            for (int j = 0; j < 5; j++) begin
                if (i - j >= 0) begin
                    y0 ^= g0[4 - j] & u[i - j];
                    y1 ^= g1[4 - j] & u[i - j];
                end
            end
            b[2 * (i % 4)]     = y0;
            b[2 * (i % 4) + 1] = y1;
            if (i % 4 == 3) begin
                exp_q.push_back(b);
                b = '0;
            end
        end
        expect_start = 1'b1;
    endfunction

    always @(posedge clk) begin
        #1;
        sym_ready = !hold_low &&
                    (int'($urandom_range(0, 99)) < ready_pct);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (sym_valid) begin
                chk("sym_valid_pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    chk("sym_byte", 32'(sym_byte), 32'(exp_q[0]));
                    if (sym_ready) begin
                        got_q.push_back(sym_byte);
                        void'(exp_q.pop_front());
                        last_xfer = cyc;
                    end
                end
            end
            if (start_out) begin
                chk("start_due", {30'd0, expect_start,
                    exp_q.size() == 0}, 32'd3);
                chk("start_vs_valid", 32'(sym_valid), 0);
                expect_start = 1'b0;
                starts++;
                last_start = cyc;
            end
        end
    end

    task automatic launch(input int len, input int gap_pct);
        int nb;
        int guard;
        bit acc;
        model(len);
        @(posedge clk);
        #2;
        go      = 1'b1;
        msg_len = 6'(len);
        @(posedge clk);
        #2;
        go = 1'b0;
        nb = (len + 7) / 8;
        for (int i = 0; i < nb; i++) begin
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 200) begin
                msg_valid = (int'($urandom_range(0, 99)) >= gap_pct);
                msg_byte  = msg_valid ? cur_bytes[i] : 8'($urandom);
                @(negedge clk);
                if (msg_valid && msg_ready) acc = 1'b1;
                @(posedge clk);
                #2;
                guard++;
            end
            if (!acc) chk("msg_accept_timeout", 0, 1);
        end
        msg_valid = 1'b0;
        @(negedge clk);
        chk("msg_ready_drop", 32'(msg_ready), 0);
    endtask

    task automatic wait_done();
        int g = 0;
        while (expect_start && g < 3000) begin
            @(negedge clk);
            g++;
        end
        chk("frame_done", 32'(expect_start), 0);
        @(negedge clk);
        chk("busy_after", 32'(busy), 0);
    endtask

    task automatic chk_0b(input string tag);
        chk({tag, "_nbytes"}, 32'(got_q.size()), 2);
        if (got_q.size() == 2) begin
            chk({tag, "_b0"}, 32'(got_q[0]), 32'h07);
            chk({tag, "_b1"}, 32'(got_q[1]), 32'hD4);
        end
    endtask

    initial begin
        int s0;
        int g;
        rst       = 1'b1;
        go        = 1'b0;
        msg_len   = '0;
        msg_byte  = '0;
        msg_valid = 1'b0;
        sym_ready = 1'b0;
        cur_bytes = '{default: 8'h00};
        @(negedge clk);
        chk("reset_outs", {24'd0, msg_ready, sym_valid, start_out,
            busy, len_err, 3'd0}, 0);
        chk("reset_sym_byte", 32'(sym_byte), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // model pinned by hand-derived symbols for 0x0B, len 4
        cur_bytes[0] = 8'h0B;
        model(4);
        chk("model_b0", 32'(exp_q[0]), 32'h07);
        chk("model_b1", 32'(exp_q[1]), 32'hD4);
        exp_q.delete();
        expect_start = 1'b0;

        // directed 0x0B, always ready
        ready_pct = 100;
        got_q.delete();
        cur_bytes[0] = 8'hFB;
        launch(4, 0);
        wait_done();
        chk_0b("dir1");
        chk("start_latency", 32'(last_start - last_xfer), 1);

        // 28 zero bits -> 8 zero bytes
        got_q.delete();
        cur_bytes = '{default: 8'h00};
        launch(28, 0);
        wait_done();
        chk("zeros_nbytes", 32'(got_q.size()), 8);
        foreach (got_q[i]) chk("zeros_byte", 32'(got_q[i]), 0);

        // rejected lengths
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #2;
            go      = 1'b1;
            msg_len = (k == 0) ? 6'd0 : 6'd29;
            @(posedge clk);
            #2;
            go = 1'b0;
            @(negedge clk);
            chk("len_err_pulse", 32'(len_err), 1);
            chk("len_err_quiet", {29'd0, msg_ready, sym_valid, busy}, 0);
            @(negedge clk);
            chk("len_err_one_cycle", 32'(len_err), 0);
        end

        // backpressure on the first symbol byte
        got_q.delete();
        hold_low = 1'b1;
        cur_bytes[0] = 8'h0B;
        launch(4, 0);
        g = 0;
        while (!sym_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 32'(sym_valid), 1);
            chk("bp_byte", 32'(sym_byte), 32'h07);
            @(negedge clk);
        end
        hold_low = 1'b0;
        wait_done();
        chk_0b("bp");

        // reset in the middle of the second symbol byte
        got_q.delete();
        s0 = starts;
        cur_bytes[0] = 8'h0B;
        launch(4, 0);
        g = 0;
        while (got_q.size() < 1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        expect_start = 1'b0;
        @(negedge clk);
        chk("mid_reset_outs", {27'd0, msg_ready, sym_valid, start_out,
            busy, len_err}, 0);
        chk("mid_reset_byte", 32'(sym_byte), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("no_start_after_reset", 32'(starts - s0), 0);
        got_q.delete();
        launch(4, 0);
        wait_done();
        chk_0b("post_reset");

        // randomized frames
        for (int f = 0; f < 60; f++) begin
            int len;
            len = int'($urandom_range(1, 28));
            for (int i = 0; i < 4; i++) cur_bytes[i] = 8'($urandom);
            ready_pct = int'($urandom_range(20, 100));
            s0 = starts;
            got_q.delete();
            launch(len, int'($urandom_range(0, 50)));
            wait_done();
            chk("rnd_nbytes", 32'(got_q.size()),
                32'((len + 4 + 3) / 4));
            chk("rnd_one_start", 32'(starts - s0), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
